// File: rtl/matrix_add_pkg.sv
// Shared constants, state encoding and index helper for the matrix adder front end.
package matrix_add_pkg;

  localparam int VEC_LEN_DEF = 6;
  localparam int NUM_VEC_DEF = 10;

  typedef enum logic {
    FILL    = 1'b0,
    DISCARD = 1'b1
  } loadState_t;

  // Flat element position of element e inside vector v.
  function automatic int elem_idx(input int v, input int e);
    return v * VEC_LEN_DEF + e;
  endfunction

endpackage

// File: rtl/elem_pair_shadow.sv
// Write-indexed register file holding the A/B pairs of a frame under assembly.
module elem_pair_shadow
  import matrix_add_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 59,
  parameter int IDX_W = 6
) (
  input  logic                   clk,
  input  logic                   wrEn,
  input  logic [IDX_W-1:0]       wrIdx,
  input  logic [WIDTH-1:0]       wrA,
  input  logic [WIDTH-1:0]       wrB,
  output logic [DEPTH*WIDTH-1:0] aFlat,
  output logic [DEPTH*WIDTH-1:0] bFlat
);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
      logic [WIDTH-1:0] aReg;
      logic [WIDTH-1:0] bReg;

      // Contents are only ever read after a full frame has overwritten them.
      always_ff @(posedge clk) begin
        if (wrEn && (wrIdx == IDX_W'(gi))) begin
          aReg <= wrA;
          bReg <= wrB;
        end
      end

      assign aFlat[gi*WIDTH +: WIDTH] = aReg;
      assign bFlat[gi*WIDTH +: WIDTH] = bReg;
    end
  endgenerate

endmodule

// File: rtl/matrix_add_loader.sv
// Serial-to-parallel frame loader: assembles A/B element pairs and publishes whole matrices at once.
module matrix_add_loader
  import matrix_add_pkg::*;
#(
  parameter int IN_WIDTH = 10,
  parameter int VEC_LEN  = VEC_LEN_DEF,
  parameter int NUM_VEC  = NUM_VEC_DEF,
  localparam int N       = VEC_LEN * NUM_VEC,
  localparam int CNT_W   = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_WIDTH-1:0]   s_a,
  input  logic [IN_WIDTH-1:0]   s_b,
  input  logic                  s_last,
  output logic [N*IN_WIDTH-1:0] A_flat,
  output logic [N*IN_WIDTH-1:0] B_flat,
  output logic                  inReady,
  output logic                  vectorSetNo,
  output logic                  frame_err
);

  loadState_t stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic accept, atLast, shadowWe, publish, errNext;
  logic [(N-1)*IN_WIDTH-1:0] shadowA, shadowB;

  assign s_ready = enable;
  assign accept  = s_valid & enable;
  assign atLast  = (cntReg == CNT_W'(N - 1));

  elem_pair_shadow #(
    .WIDTH(IN_WIDTH),
    .DEPTH(N - 1),
    .IDX_W(CNT_W)
  ) uShadow (
    .clk  (clk),
    .wrEn (shadowWe),
    .wrIdx(cntReg),
    .wrA  (s_a),
    .wrB  (s_b),
    .aFlat(shadowA),
    .bFlat(shadowB)
  );

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    shadowWe  = 1'b0;
    publish   = 1'b0;
    errNext   = 1'b0;
    if (accept) begin
      case (stateReg)
        FILL: begin
          if (atLast) begin
            // Final slot is taken straight from the beat, so a missing last still publishes.
            publish = 1'b1;
            cntNext = '0;
            if (!s_last) begin
              errNext   = 1'b1;
              stateNext = DISCARD;
            end
          end else if (s_last) begin
            cntNext = '0;
            errNext = 1'b1;
          end else begin
            shadowWe = 1'b1;
            cntNext  = cntReg + CNT_W'(1);
          end
        end
        DISCARD: begin
          if (s_last) begin
            stateNext = FILL;
            cntNext   = '0;
          end
        end
        default: stateNext = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg    <= FILL;
      cntReg      <= '0;
      A_flat      <= '0;
      B_flat      <= '0;
      inReady     <= 1'b0;
      vectorSetNo <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      cntReg    <= cntNext;
      inReady   <= publish;
      frame_err <= errNext;
      if (publish) begin
        A_flat      <= {s_a, shadowA};
        B_flat      <= {s_b, shadowB};
        vectorSetNo <= ~vectorSetNo;
      end
    end
  end

endmodule

// File: doc/matrix_add_loader.md
# matrix_add_loader

Upstream feeder for the 10-vector x 6-element parallel matrix adder. Accepts a serial stream of (A, B) element pairs over a valid/ready handshake and assembles them into a shadow buffer. On frame completion it publishes the whole matrix pair at once to held, flat parallel outputs and pulses `inReady` for one cycle. The adder downstream has no ready/hold-request input, so published outputs stay stable until the next frame completes.

## Interface
- `IN_WIDTH`, 10, signed element width
- `VEC_LEN`, 6, elements per vector
- `NUM_VEC`, 10, vectors per matrix; frame length N = VEC_LEN*NUM_VEC (60)
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `enable`  in  1  global enable; low freezes all state
- `s_valid`  in  1  input beat valid
- `s_ready`  out  1  equals `enable` (registered-free); beat accepted when `s_valid & s_ready` at rising edge
- `s_a`, `s_b`  in  IN_WIDTH each  signed A and B element of current beat
- `s_last`  in  1  marks final beat of a frame
- `A_flat`, `B_flat`  out  N*IN_WIDTH each  published matrices; element k occupies bits [(k+1)*IN_WIDTH-1 : k*IN_WIDTH]
- `inReady`  out  1  one-cycle pulse: new matrices published
- `vectorSetNo`  out  1  toggles on every publish
- `frame_err`  out  1  one-cycle pulse on frame length mismatch

## Operation
- Element order: k = v*VEC_LEN + e, where v is the vector index (0..NUM_VEC-1) and e the element index. Beat j of a frame is element k = j. So beats 0..5 are elements 0..5 of vector 0, and beats 6..11 start vector 1.
- Internal state:
  - beat counter `cnt`, 0..N-1, width $clog2(N)
  - shadow buffers for A and B, N-1 entries each
  - state register: FILL, DISCARD
- FILL, accepted beat with cnt < N-1:
  - `s_last`=0: write shadow[cnt], cnt++.
  - `s_last`=1 (early last): discard the partial frame, cnt←0, pulse `frame_err`, no publish, published outputs unchanged.
- FILL, accepted beat with cnt = N-1:
  - Copy shadow[0..N-2] plus the current beat into `A_flat`/`B_flat`.
  - Pulse `inReady`, toggle `vectorSetNo`, cnt←0.
  - If `s_last`=0 (missing last): the frame is still published, `frame_err` pulses in the same cycle as `inReady`, state→DISCARD.
- DISCARD: accepted beats are dropped. An accepted beat with `s_last`=1 sets state→FILL, cnt←0. No `frame_err` is issued while in DISCARD.
- Filling resumes on the very next beat after a publish, because the shadow and published registers are separate. Back-to-back frames with no idle cycles are supported.
- No arithmetic is performed; values pass through bit-exact with sign preserved.
- `enable`=0: `s_ready`=0, no state changes. A pending pulse output still deasserts after its one cycle; pulses are not stretched.

## Timing
- Reset (async assert, synchronous-safe release) values:
  - `A_flat`, `B_flat`, `cnt`: all zero
  - state: FILL
  - `inReady`: 0
  - `vectorSetNo`: 0
  - `frame_err`: 0
- Publish latency: final beat accepted at edge t means `A_flat`, `B_flat`, `vectorSetNo` and `inReady`=1 are all valid during cycle t..t+1. `inReady` is 0 again after edge t+1.
- Minimum publish spacing is N cycles.
- Published outputs change only at a publish edge.
- Reset mid-frame: the partial frame is lost. The first beat after release is element 0.

## Structure
- Shared package `matrix_add_pkg`:
  - constants VEC_LEN_DEF=6, NUM_VEC_DEF=10
  - function `elem_idx(v, e)`
  - state enum {FILL, DISCARD}
- One sub-module, `elem_pair_shadow`:
  - N-1 deep write-indexed register file for A/B pairs
  - write enable, write index, flat read-out
  - the loader instantiates it once

## Test plan
- Reset, then 60 beats with a(k)=k, b(k)=-k, `s_last` on beat 59, `s_valid` held high:
  - exactly one `inReady` pulse, 1 cycle after beat 59
  - A element 37 = 37, B element 37 = -37 (10'h3DB)
  - `vectorSetNo`=1, `frame_err` never high
- Two back-to-back frames, second with a(k)=511, b(k)=-512:
  - two `inReady` pulses 60 cycles apart
  - outputs of frame 1 held unchanged until the second pulse
  - `vectorSetNo` returns to 0
- `s_last` on beat 20, then a full correct frame:
  - `frame_err` pulse 1 cycle after beat 20, no `inReady` for the partial frame
  - the next 60 beats publish correctly with element 0 = first beat after the error
- 65 beats with `s_last` only on beat 64:
  - publish with `frame_err` after beat 59
  - beats 60..64 dropped, the following frame publishes correctly
- `enable` low for 7 cycles mid-frame with `s_valid` high:
  - `s_ready` low, cnt frozen
  - the frame completes 7 cycles later with correct contents
- Assert `reset` at beat 30:
  - all outputs zero immediately (asynchronous)
  - after release, a full frame publishes with element 0 = first post-reset beat
